barrel_shifter_pipe: RTL



---
 rtl/barrel_shifter_pipe_if.sv | 35 +++
 rtl/barrel_shifter_pipe.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/barrel_shifter_pipe_if.sv
// Valid/ready bus for barrel_shifter_pipe: operand side (i_*) in, result side (o_*) out.
// o_carry exists only when BARREL_SHIFTER_PIPE_CARRY_EN is defined.
interface barrel_shifter_pipe_if #(
   parameter int N = 3
);
   localparam int W = 2 ** N;

   logic [W-1:0] i_data;
   logic [N-1:0] i_amount;
   logic [1:0]   i_mode;
   logic         i_valid;
   logic         o_ready;
   logic [W-1:0] o_data;
   logic         o_valid;
   logic         i_ready;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
   logic         o_carry;
`endif

   modport master (
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
      input  o_carry,
`endif
      output i_data, i_amount, i_mode, i_valid, i_ready,
      input  o_ready, o_data, o_valid
   );

   modport slave (
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
      output o_carry,
`endif
      input  i_data, i_amount, i_mode, i_valid, i_ready,
      output o_ready, o_data, o_valid
   );
endinterface

// File: rtl/barrel_shifter_pipe.sv
// Pipelined barrel shifter: one register stage per mux level (shift 2**k at stage k), SHL/SHR/SRA/ROTL.
// Optional BARREL_SHIFTER_PIPE_CARRY_EN adds o_carry, the last bit shifted out, aligned with o_data.
module barrel_shifter_pipe #(
   parameter int N = 3
) (
   input logic                  i_clk,
   input logic                  i_rst_n,
   barrel_shifter_pipe_if.slave bus
);
   localparam int W = 2 ** N;

   typedef enum logic [1:0] {
      MODE_SHL  = 2'b00,
      MODE_SHR  = 2'b01,
      MODE_SRA  = 2'b10,
      MODE_ROTL = 2'b11
   } mode_e;

   // Stage registers; index k holds the beat after the 2**k level has been applied.
   logic [N-1:0] v_q;
   logic [W-1:0] d_q [N];
   mode_e        m_q [N];
   logic [N-1:0] a_q [N];
   logic         s_q [N];

   // Stage inputs (upstream view) and next payload.
   logic         in_v [N];
   logic [W-1:0] in_d [N];
   mode_e        in_m [N];
   logic [N-1:0] in_a [N];
   logic         in_s [N];
   logic [W-1:0] nxt_d [N];
   logic [N-1:0] en;

`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
   logic c_q   [N];
   logic c_in  [N];
   logic c_nxt [N];
`endif

   function automatic logic [W-1:0] shift_stage(input logic [W-1:0] d, input mode_e m,
                                                 input logic sign, input int s);
      logic [W-1:0] r;
      case (m)
         MODE_SHL: r = d << s;
         MODE_SHR: r = d >> s;
         MODE_SRA: r = (d >> s) | (sign ? ~({W{1'b1}} >> s) : '0);
         default:  r = (d << s) | (d >> (W - s));
      endcase
      return r;
   endfunction

`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
   function automatic logic shift_carry(input logic [W-1:0] d, input mode_e m, input int s);
      logic [W-1:0] t;
      case (m)
         MODE_SHL:          t = d >> (W - s);
         MODE_SHR, MODE_SRA: t = d >> (s - 1);
         default:           t = '0;
      endcase
      return t[0];
   endfunction
`endif

   // A stage may load when it, or any stage downstream of it, is empty, or the sink is taking a beat.
   always_comb begin
      en = '0;
      for (int k = 0; k < N; k++) begin
         en[k] = bus.i_ready;
         for (int j = k; j < N; j++)
            if (!v_q[j]) en[k] = 1'b1;
      end
   end

   always_comb begin
      in_v[0] = bus.i_valid;
      in_d[0] = bus.i_data;
      in_m[0] = mode_e'(bus.i_mode);
      in_a[0] = bus.i_amount;
      in_s[0] = bus.i_data[W-1];
      for (int k = 1; k < N; k++) begin
         in_v[k] = v_q[k-1];
         in_d[k] = d_q[k-1];
         in_m[k] = m_q[k-1];
         in_a[k] = a_q[k-1];
         in_s[k] = s_q[k-1];
      end
      for (int k = 0; k < N; k++)
         nxt_d[k] = in_a[k][k] ? shift_stage(in_d[k], in_m[k], in_s[k], 2 ** k) : in_d[k];
   end

`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
   always_comb begin
      c_in[0] = 1'b0;
      for (int k = 1; k < N; k++)
         c_in[k] = c_q[k-1];
      for (int k = 0; k < N; k++)
         c_nxt[k] = in_a[k][k] ? shift_carry(in_d[k], in_m[k], 2 ** k) : c_in[k];
   end
`endif

   // NOTE: non-blocking assignments let every stage capture its neighbour's pre-edge value in one loop.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         v_q <= '0;
         // NOTE: payload registers are reset as well as the valid bits, so o_data reads 0 after reset.
         for (int k = 0; k < N; k++) begin
            d_q[k] <= '0;
            m_q[k] <= MODE_SHL;
            a_q[k] <= '0;
            s_q[k] <= 1'b0;
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
            c_q[k] <= 1'b0;
`endif
         end
      end else begin
         for (int k = 0; k < N; k++) begin
            if (en[k]) begin
               v_q[k] <= in_v[k];
               // Bubbles only clear the valid bit; the payload keeps its last beat.
               if (in_v[k]) begin
                  d_q[k] <= nxt_d[k];
                  m_q[k] <= in_m[k];
                  a_q[k] <= in_a[k];
                  s_q[k] <= in_s[k];
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
                  c_q[k] <= c_nxt[k];
`endif
               end
            end
         end
      end
   end

   assign bus.o_ready = en[0];
   assign bus.o_valid = v_q[N-1];
   assign bus.o_data  = d_q[N-1];
`ifdef BARREL_SHIFTER_PIPE_CARRY_EN
   assign bus.o_carry = c_q[N-1];
`endif

endmodule
